hazard_unit: RTL

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit.sv | 106 ++++++++++
 1 files changed

// File: rtl/hazard_unit.sv
// Decode-stage hazard detection: per-stage scoreboard, stall and forwarding selects.
// Optional stall-cycle counter enabled by defining HAZARD_STALL_STATS_EN.
module hazard_unit #(
   parameter int STAGES  = 3,
   parameter int STAGE_W = 2,
   parameter int ADDR_W  = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [ADDR_W-1:0]  rd_addr0,
   input  logic [ADDR_W-1:0]  rd_addr1,
   input  logic [STAGE_W-1:0] rd_stage0,
   input  logic [STAGE_W-1:0] rd_stage1,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [STAGE_W-1:0] wr_stage,
   input  logic               flush,
   output logic               stall,
   output logic [STAGE_W-1:0] fwd_sel0,
   output logic [STAGE_W-1:0] fwd_sel1,
   output logic [31:0]        stall_count
);

   logic [STAGES:1]    ent_v;
   logic [ADDR_W-1:0]  ent_a [1:STAGES];
   logic [STAGE_W-1:0] ent_w [1:STAGES];

   logic [ADDR_W-1:0]  ra [2];
   logic [STAGE_W-1:0] rs [2];
   logic [1:0]         need;
   logic [STAGE_W-1:0] sel [2];
   logic               hit;
   int                 hk;
   logic [STAGE_W-1:0] mw;

   assign ra[0] = rd_addr0;
   assign ra[1] = rd_addr1;
   assign rs[0] = rd_stage0;
   assign rs[1] = rd_stage1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ent_v <= '0;
         for (int k = 1; k <= STAGES; k++) begin
            ent_a[k] <= '0;
            ent_w[k] <= '0;
         end
      end else begin
         ent_v[1] <= ~stall & ~flush & (wr_addr != '0);
         ent_a[1] <= wr_addr;
         ent_w[1] <= wr_stage;
         for (int k = 2; k <= STAGES; k++) begin
            ent_v[k] <= ent_v[k-1];
            ent_a[k] <= ent_a[k-1];
            ent_w[k] <= ent_w[k-1];
         end
      end
   end

   // Scan oldest to youngest so the youngest matching entry wins.
   always_comb begin
      need = '0;
      sel[0] = '0;
      sel[1] = '0;
      hit = 1'b0;
      hk = 0;
      mw = '0;
      for (int p = 0; p < 2; p++) begin
         hit = 1'b0;
         hk = 0;
         mw = '0;
         for (int k = STAGES; k >= 1; k--) begin
            if (ent_v[k] && ent_a[k] == ra[p] && ra[p] != '0) begin
               hit = 1'b1;
               hk = k;
               mw = ent_w[k];
            end
         end
         if (hit) begin
            if (int'(rs[p]) < STAGES && hk + int'(rs[p]) <= int'(mw))
               need[p] = 1'b1;
            if (hk > int'(mw))
               sel[p] = STAGE_W'(hk);
         end
      end
   end

   assign stall    = |need;
   assign fwd_sel0 = sel[0];
   assign fwd_sel1 = sel[1];

`ifdef HAZARD_STALL_STATS_EN
   logic [31:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (stall && cnt != '1)
         cnt <= cnt + 32'd1;
   end

   assign stall_count = cnt;
`else
   assign stall_count = '0;
`endif

endmodule
